// File: rtl/beacon_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : beacon_pkg
//  Purpose  : Shared class encoding for the beacon frequency classifier.
//             NONE / FRIENDLY / CRIMINAL codes and the 2-bit class type.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package beacon_pkg;

    localparam int CLS_W = 2;

    typedef logic [CLS_W-1:0] cls_t;

    localparam cls_t CLS_NONE     = 2'b00;
    localparam cls_t CLS_FRIENDLY = 2'b01;
    localparam cls_t CLS_CRIMINAL = 2'b10;
    // 2'b11 is reserved and never produced.

endpackage : beacon_pkg
`default_nettype wire

// File: rtl/beacon_edge_counter.sv
`default_nettype none
// ============================================================================
//  Module   : beacon_edge_counter
//  Purpose  : One sensor channel front end: 2-flop synchroniser, both-edge
//             detector and saturating toggle counter cleared per window.
//  Ports    : clk         - system clock
//             rst         - synchronous active-high reset
//             pulse_in    - raw asynchronous sensor input
//             window_tick - last cycle of the counting window
//             total_cnt   - running count including this cycle's edge
//  Revision : 1.0 - initial release
// ============================================================================
module beacon_edge_counter #(
    parameter int CNT_W = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pulse_in,
    input  logic             window_tick,
    output logic [CNT_W-1:0] total_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_prev;
    logic [CNT_W-1:0] r_count;
    logic             w_edge;

    assign w_edge = r_sync2 ^ r_prev;

    // Saturating add of the current edge; this is the value the window is
    // judged on when window_tick is high.
    assign total_cnt = (w_edge && (r_count != c_cnt_max)) ? r_count + CNT_W'(1) : r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_count <= '0;
        end else begin
            r_sync1 <= pulse_in;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            // An edge on the tick cycle also opens the next window's count.
            if (window_tick) begin
                r_count <= {{(CNT_W-1){1'b0}}, w_edge};
            end else begin
                r_count <= total_cnt;
            end
        end
    end

endmodule : beacon_edge_counter
`default_nettype wire

// File: rtl/beacon_freq_classifier.sv
`default_nettype none
// ============================================================================
//  Module   : beacon_freq_classifier
//  Purpose  : N-channel beacon frequency classifier. Counts toggles per
//             channel over a fixed window, classes the count and publishes a
//             class once CONFIRM consecutive windows agree.
//  Ports    : clk         - system clock
//             rst         - synchronous active-high reset
//             pulse_in    - raw sensor inputs, one bit per channel
//             class_out   - published class, channel i at [2i+1:2i]
//             class_chg   - 1-cycle pulse when a channel's class_out changes
//             window_tick - 1-cycle pulse on the last cycle of each window
//             ch_count    - per-channel count latched at the last window end
//  Revision : 1.0 - initial release
// ============================================================================
module beacon_freq_classifier
    import beacon_pkg::*;
#(
    parameter int          NUM_CH     = 2,
    parameter int          WINDOW_CYC = 50_000_000,
    parameter int          CNT_W      = 11,
    parameter int unsigned LOW_THR    = 100,
    parameter int unsigned HIGH_THR   = 950,
    parameter int          CONFIRM    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       pulse_in,
    output logic [2*NUM_CH-1:0]     class_out,
    output logic [NUM_CH-1:0]       class_chg,
    output logic                    window_tick,
    output logic [CNT_W*NUM_CH-1:0] ch_count
);

    localparam int c_tmr_w = (WINDOW_CYC > 1) ? $clog2(WINDOW_CYC) : 1;
    localparam int c_run_w = $clog2(CONFIRM + 1);
    localparam logic [c_tmr_w-1:0] c_tmr_last = c_tmr_w'(WINDOW_CYC - 1);
    localparam logic [c_run_w-1:0] c_run_max  = c_run_w'(CONFIRM);

    logic [c_tmr_w-1:0] r_timer;
    logic [c_tmr_w-1:0] w_timer_nxt;
    logic               r_tick;

    function automatic cls_t classify(input logic [CNT_W-1:0] cnt);
        logic [31:0] v;
        v = 32'(cnt);
        if (v < LOW_THR) begin
            return CLS_NONE;
        end else if (v <= HIGH_THR) begin
            return CLS_FRIENDLY;
        end else begin
            return CLS_CRIMINAL;
        end
    endfunction

    assign w_timer_nxt = (r_timer == c_tmr_last) ? '0 : r_timer + c_tmr_w'(1);

    // The tick is registered from the next timer value so it is high exactly
    // while the timer sits at its last count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timer <= '0;
            r_tick  <= 1'b0;
        end else begin
            r_timer <= w_timer_nxt;
            r_tick  <= (w_timer_nxt == c_tmr_last);
        end
    end

    assign window_tick = r_tick;

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            logic [CNT_W-1:0]   w_total;
            cls_t               w_raw;
            cls_t               w_cand_nxt;
            logic [c_run_w-1:0] w_run_nxt;
            cls_t               r_cand;
            logic [c_run_w-1:0] r_run;
            cls_t               r_out;
            logic               r_chg;
            logic [CNT_W-1:0]   r_cnt;

            beacon_edge_counter #(
                .CNT_W (CNT_W)
            ) u_cnt (
                .clk         (clk),
                .rst         (rst),
                .pulse_in    (pulse_in[i]),
                .window_tick (r_tick),
                .total_cnt   (w_total)
            );

            // Candidate tracking: a repeat of the candidate extends the run
            // (capped), anything else restarts it at one.
            always_comb begin
                w_raw      = classify(w_total);
                w_cand_nxt = w_raw;
                w_run_nxt  = c_run_w'(1);
                if (w_raw == r_cand) begin
                    w_cand_nxt = r_cand;
                    w_run_nxt  = (r_run == c_run_max) ? c_run_max : r_run + c_run_w'(1);
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cand <= CLS_NONE;
                    r_run  <= '0;
                    r_out  <= CLS_NONE;
                    r_chg  <= 1'b0;
                    r_cnt  <= '0;
                end else begin
                    r_chg <= 1'b0;
                    if (r_tick) begin
                        r_cand <= w_cand_nxt;
                        r_run  <= w_run_nxt;
                        r_cnt  <= w_total;
                        if ((w_run_nxt == c_run_max) && (w_cand_nxt != r_out)) begin
                            r_out <= w_cand_nxt;
                            r_chg <= 1'b1;
                        end
                    end
                end
            end

            assign class_out[2*i +: 2]       = r_out;
            assign class_chg[i]              = r_chg;
            assign ch_count[CNT_W*i +: CNT_W] = r_cnt;
        end
    endgenerate

endmodule : beacon_freq_classifier
`default_nettype wire
